// File: rtl/sprdma_if.sv
// CPU-side bus bundle for the sprite DMA engine: trigger decode inputs,
// memory read data, and the DMA-driven memory bus.
interface sprdma_if;
   logic [15:0] cpu_a_in;
   logic [7:0]  cpu_d_in;
   logic        cpu_r_nw_in;
   logic [7:0]  mem_d_in;
   logic        active_out;
   logic [15:0] mem_a_out;
   logic [7:0]  mem_d_out;
   logic        mem_r_nw_out;

   modport slave (
      input  cpu_a_in, cpu_d_in, cpu_r_nw_in, mem_d_in,
      output active_out, mem_a_out, mem_d_out, mem_r_nw_out
   );

   modport master (
      output cpu_a_in, cpu_d_in, cpu_r_nw_in, mem_d_in,
      input  active_out, mem_a_out, mem_d_out, mem_r_nw_out
   );
endinterface

// File: rtl/sprdma.sv
// Sprite DMA: a CPU write to 0x4014 copies page {data,00..FF} into OAM by
// alternating a memory read with a write to 0x2004, stalling the CPU meanwhile.
module sprdma (
   input  logic     clk_in,
   input  logic     rst_in,
   sprdma_if.slave  bus
);
   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_READ, S_WRITE, S_COOLDOWN
   } state_t;

   state_t     q_state, w_state;
   logic [7:0] q_page, w_page;
   logic [7:0] q_idx, w_idx;
   logic [7:0] q_data, w_data;

   logic        w_active;
   logic [15:0] w_mem_a;
   logic [7:0]  w_mem_d;
   logic        w_mem_r_nw;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         q_state <= S_IDLE;
         q_page  <= 8'h00;
         q_idx   <= 8'h00;
         q_data  <= 8'h00;
      end else begin
         q_state <= w_state;
         q_page  <= w_page;
         q_idx   <= w_idx;
         q_data  <= w_data;
      end
   end

   // Terminal check precedes the increment, so q_idx never wraps mid-transfer.
   always_comb begin
      w_state = q_state;
      w_page  = q_page;
      w_idx   = q_idx;
      w_data  = q_data;
      case (q_state)
         S_IDLE: begin
            if (bus.cpu_a_in == DMA_REG_ADDR && !bus.cpu_r_nw_in) begin
               w_page  = bus.cpu_d_in;
               w_idx   = 8'h00;
               w_state = S_START;
            end
         end
         S_START: w_state = S_READ;
         S_READ: begin
            w_data  = bus.mem_d_in;
            w_state = S_WRITE;
         end
         S_WRITE: begin
            if (q_idx == 8'hFF) begin
               w_state = S_COOLDOWN;
            end else begin
               w_idx   = q_idx + 8'd1;
               w_state = S_READ;
            end
         end
         S_COOLDOWN: w_state = S_IDLE;
         default:    w_state = S_IDLE;
      endcase
   end

   // Outputs decode registered state only; no path from the cpu_* inputs.
   always_comb begin
      w_active   = 1'b0;
      w_mem_a    = 16'h0000;
      w_mem_d    = 8'h00;
      w_mem_r_nw = 1'b1;
      case (q_state)
         S_START: w_active = 1'b1;
         S_READ: begin
            w_active = 1'b1;
            w_mem_a  = {q_page, q_idx};
         end
         S_WRITE: begin
            w_active   = 1'b1;
            w_mem_a    = OAM_DATA_ADDR;
            w_mem_d    = q_data;
            w_mem_r_nw = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.active_out   = w_active;
   assign bus.mem_a_out    = w_mem_a;
   assign bus.mem_d_out    = w_mem_d;
   assign bus.mem_r_nw_out = w_mem_r_nw;
endmodule

// File: tb/tb_sprdma.sv
// Directed bench for sprdma: cycle-indexed model of each transfer checked
// against the memory bus, plus reset, non-trigger and retrigger cases.
module tb_sprdma;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic [7:0] mem [0:65535];
   int checks = 0;
   int errors = 0;

   sprdma_if bus();

   sprdma dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   assign bus.mem_d_in = mem[bus.mem_a_out];

   function automatic logic [7:0] mbyte(input logic [15:0] a);
      if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
      return a[7:0] ^ a[15:8] ^ 8'hC3;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rnw);
      bus.cpu_a_in    = a;
      bus.cpu_d_in    = d;
      bus.cpu_r_nw_in = rnw;
   endtask

   task automatic idle_in();
      drive(16'h0000, 8'h00, 1'b1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_act"}, {15'd0, bus.active_out}, 16'h0000);
      chk({tag, "_a"},   bus.mem_a_out, 16'h0000);
      chk({tag, "_d"},   {8'd0, bus.mem_d_out}, 16'h0000);
      chk({tag, "_rnw"}, {15'd0, bus.mem_r_nw_out}, 16'h0001);
   endtask

   // Caller has the trigger on the bus; cycle c = T+c after the trigger edge.
   // Returns in cycle T+515 (IDLE) with cpu inputs idle.
   task automatic xfer(input logic [7:0] p, input bit retrig);
      int acts = 0;
      int wrs  = 0;
      logic [15:0] ea;
      logic [7:0]  ed;
      logic        erw, eact;
      for (int c = 1; c <= 515; c++) begin
         step();
         ea = 16'h0000; ed = 8'h00; erw = 1'b1; eact = 1'b0;
         if (c == 1) begin
            eact = 1'b1;
         end else if (c <= 513) begin
            eact = 1'b1;
            if (c % 2 == 0) begin
               ea = {p, 8'((c - 2) / 2)};
            end else begin
               ea  = 16'h2004;
               ed  = mbyte({p, 8'((c - 3) / 2)});
               erw = 1'b0;
            end
         end
         chk($sformatf("p%02h_c%0d_act", p, c), {15'd0, bus.active_out}, {15'd0, eact});
         chk($sformatf("p%02h_c%0d_a", p, c), bus.mem_a_out, ea);
         chk($sformatf("p%02h_c%0d_rnw", p, c), {15'd0, bus.mem_r_nw_out}, {15'd0, erw});
         if (c == 1 || c >= 514 || c % 2 == 1)
            chk($sformatf("p%02h_c%0d_d", p, c), {8'd0, bus.mem_d_out}, {8'd0, ed});
         acts += int'(bus.active_out);
         wrs  += int'(!bus.mem_r_nw_out);
         if (retrig && (c == 10 || c == 300 || c == 514)) drive(16'h4014, 8'h77, 1'b0);
         else idle_in();
      end
      chk($sformatf("p%02h_act_cycles", p), 16'(acts), 16'd513);
      chk($sformatf("p%02h_writes", p), 16'(wrs), 16'd256);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = mbyte(16'(a));
      idle_in();

      // Reset state
      rst_in = 1'b1;
      step(); step();
      chk_idle("reset");
      rst_in = 1'b0;
      step();
      chk_idle("post_reset");

      // Read of 0x4014 and write of 0x4015 must not trigger
      drive(16'h4014, 8'h02, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rd4014_act", {15'd0, bus.active_out}, 16'h0000);
      end
      drive(16'h4015, 8'h02, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("wr4015_act", {15'd0, bus.active_out}, 16'h0000);
      end
      idle_in();
      step();

      // Page 0x02 with i ^ 0x5A contents
      drive(16'h4014, 8'h02, 1'b0);
      xfer(8'h02, 1'b0);
      step();
      chk_idle("after_p02");

      // Retriggers mid-transfer and in COOLDOWN ignored; page stays 0x40
      drive(16'h4014, 8'h40, 1'b0);
      xfer(8'h40, 1'b0 | 1'b1);
      step();
      chk_idle("after_retrig");
      step();
      chk_idle("after_retrig2");

      // Page 0xFF, then a trigger in the first IDLE cycle is accepted
      drive(16'h4014, 8'hFF, 1'b0);
      xfer(8'hFF, 1'b0);
      drive(16'h4014, 8'h10, 1'b0);
      xfer(8'h10, 1'b0);

      // Reset during byte 100 WRITE
      drive(16'h4014, 8'h33, 1'b0);
      step();
      idle_in();
      chk("mid_start_act", {15'd0, bus.active_out}, 16'h0001);
      repeat (202) step();
      chk("mid_b100_a", bus.mem_a_out, 16'h2004);
      chk("mid_b100_d", {8'd0, bus.mem_d_out}, {8'd0, mbyte(16'h3364)});
      rst_in = 1'b1;
      step();
      chk_idle("rst_mid");
      rst_in = 1'b0;
      step();
      chk_idle("rst_mid_hold");
      drive(16'h4014, 8'h05, 1'b0);
      xfer(8'h05, 1'b0);
      step();
      chk_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
